// File: rtl/led_pkg.sv
// Shared constants and the saturating decay helper for the LED fade/PWM slice.
package led_pkg;

    localparam int PWM_BITS_DEFAULT = 8;
    localparam logic [PWM_BITS_DEFAULT-1:0] LEVEL_MAX = {PWM_BITS_DEFAULT{1'b1}};

    // Subtract that floors at zero instead of wrapping.
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if (a > b) begin
            r = a - b;
        end else begin
            r = 32'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level with linear decay, period-aligned duty shadow,
// and the registered PWM comparator output.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS   = PWM_BITS_DEFAULT,
    parameter int DECAY_STEP = 16
) (
    input  logic                iCE_CLK,
    input  logic                rst,
    input  logic                pattern_bit,
    input  logic                pattern_q_bit,
    input  logic                valid,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wrap,
    input  logic                enable,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] CH_MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] level_r;
    logic [PWM_BITS-1:0] duty_r;
    logic                led_r;
    logic                eff_s;
    logic [PWM_BITS-1:0] level_dec_s;
    logic [PWM_BITS-1:0] level_nxt_s;

    // Next brightness: a fresh set bit wins, then decay on tick, then hold.
    always_comb begin
        eff_s       = pattern_q_bit;
        level_nxt_s = level_r;
        level_dec_s = PWM_BITS'(sat_sub(32'(level_r), 32'(DECAY_STEP)));
        if (valid) begin
            eff_s = pattern_bit;
        end else begin
            eff_s = pattern_q_bit;
        end
        if (valid && pattern_bit) begin
            level_nxt_s = CH_MAX;
        end else if (tick && !eff_s) begin
            level_nxt_s = level_dec_s;
        end else if (eff_s) begin
            level_nxt_s = CH_MAX;
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Level, duty shadow (loaded only on period wrap) and LED drive flop.
    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) begin
            level_r <= '0;
            duty_r  <= '0;
            led_r   <= 1'b0;
        end else begin
            level_r <= level_nxt_s;
            if (wrap) begin
                duty_r <= level_r;
            end else begin
                duty_r <= duty_r;
            end
            led_r <= enable & (pwm_cnt < duty_r);
        end
    end

    assign led = led_r;

endmodule

// File: rtl/led_fade_pwm.sv
// Comet-tail LED driver: shared PWM counter, decay prescaler and pattern latch
// feeding N_LED independent fading PWM channels.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int N_LED      = 8,
    parameter int PWM_BITS   = PWM_BITS_DEFAULT,
    parameter int TICK_DIV   = 60000,
    parameter int DECAY_STEP = 16
) (
    input  logic             iCE_CLK,
    input  logic             rst,
    input  logic [N_LED-1:0] pattern_in,
    input  logic             pattern_valid,
    input  logic             enable,
    output logic [N_LED-1:0] led_out
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [PRE_W-1:0]    presc_r;
    logic [N_LED-1:0]    pat_q_r;
    logic                tick_s;
    logic                wrap_s;

    assign tick_s = (presc_r == PRE_W'(TICK_DIV - 1));
    assign wrap_s = (pwm_cnt_r == {PWM_BITS{1'b1}});

    // Free-running PWM counter, decay prescaler and latched pattern.
    always_ff @(posedge iCE_CLK or posedge rst) begin
        if (rst) begin
            pwm_cnt_r <= '0;
            presc_r   <= '0;
            pat_q_r   <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
            if (tick_s) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PRE_W'(1);
            end
            if (pattern_valid) begin
                pat_q_r <= pattern_in;
            end else begin
                pat_q_r <= pat_q_r;
            end
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .DECAY_STEP(DECAY_STEP)
        ) u_ch (
            .iCE_CLK      (iCE_CLK),
            .rst          (rst),
            .pattern_bit  (pattern_in[i]),
            .pattern_q_bit(pat_q_r[i]),
            .valid        (pattern_valid),
            .tick         (tick_s),
            .pwm_cnt      (pwm_cnt_r),
            .wrap         (wrap_s),
            .enable       (enable),
            .led          (led_out[i])
        );
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: vector table, directed fade sequences,
// and randomized traffic against a per-cycle arithmetic reference model.
module tb_led_fade_pwm;

    localparam int N   = 8;
    localparam int PB  = 4;
    localparam int TD  = 8;
    localparam int DS  = 4;
    localparam int PER = 16;
    localparam int MX  = 15;

    logic         iCE_CLK = 1'b0;
    logic         rst;
    logic [N-1:0] pattern_in;
    logic         pattern_valid;
    logic         enable;
    logic [N-1:0] led_out;

    always #5 iCE_CLK = ~iCE_CLK;

    led_fade_pwm #(
        .N_LED     (N),
        .PWM_BITS  (PB),
        .TICK_DIV  (TD),
        .DECAY_STEP(DS)
    ) dut (
        .iCE_CLK      (iCE_CLK),
        .rst          (rst),
        .pattern_in   (pattern_in),
        .pattern_valid(pattern_valid),
        .enable       (enable),
        .led_out      (led_out)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int       m_cnt;
    int       m_presc;
    logic [N-1:0] m_patq;
    int       m_level [N];
    int       m_duty  [N];
    logic [N-1:0] m_led;
    int       hc [N];

    typedef struct {
        logic [N-1:0] pat;
        logic         en;
        logic [N-1:0] exp_on;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_presc = 0;
        m_patq  = '0;
        m_led   = '0;
        for (int i = 0; i < N; i++) begin
            m_level[i] = 0;
            m_duty[i]  = 0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            bit tick = (m_presc == TD - 1);
            bit wrap = (m_cnt == PER - 1);
            logic [N-1:0] eff = pattern_valid ? pattern_in : m_patq;
            for (int i = 0; i < N; i++) begin
                m_led[i] = enable && (m_cnt < m_duty[i]);
                if (wrap) m_duty[i] = m_level[i];
                if (eff[i]) m_level[i] = MX;
                else if (tick) m_level[i] = (m_level[i] > DS) ? m_level[i] - DS : 0;
            end
            if (pattern_valid) m_patq = pattern_in;
            m_cnt   = (m_cnt + 1) % PER;
            m_presc = (m_presc + 1) % TD;
        end
    endtask

    task automatic step();
        @(posedge iCE_CLK);
        model_edge();
        #1;
        chk("led_out_cycle", int'(led_out), int'(m_led));
    endtask

    task automatic count_window(input int n);
        for (int i = 0; i < N; i++) hc[i] = 0;
        repeat (n) begin
            step();
            pattern_valid = 1'b0;
            for (int i = 0; i < N; i++) hc[i] += int'(led_out[i]);
        end
    endtask

    function automatic int hc_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += hc[i];
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pattern_valid = 1'b0;
        #1;
        model_reset();
        chk("reset_async_led", int'(led_out), 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pattern_in = '0;
        pattern_valid = 1'b0;
        enable = 1'b1;

        vecs[0] = '{pat: 8'h01, en: 1'b1, exp_on: 8'h01};
        vecs[1] = '{pat: 8'hA5, en: 1'b1, exp_on: 8'hA5};
        vecs[2] = '{pat: 8'hFF, en: 1'b0, exp_on: 8'h00};
        vecs[3] = '{pat: 8'h80, en: 1'b1, exp_on: 8'h80};
        vecs[4] = '{pat: 8'h00, en: 1'b1, exp_on: 8'h00};

        // table: load at edge 1, dark first period, full-on second period
        for (int k = 0; k < 5; k++) begin
            do_reset();
            pattern_in = vecs[k].pat;
            enable = vecs[k].en;
            pattern_valid = 1'b1;
            count_window(16);
            chk($sformatf("vec%0d_first_period", k), hc_sum(), 0);
            count_window(16);
            for (int i = 0; i < N; i++)
                chk($sformatf("vec%0d_ch%0d", k, i), hc[i], vecs[k].exp_on[i] ? 15 : 0);
        end

        // fade: ch0 on, then hand over to ch1; one-period lag on duty
        enable = 1'b1;
        do_reset();
        pattern_in = 8'h01; pattern_valid = 1'b1;
        step();
        pattern_valid = 1'b0;
        repeat (15) step();
        pattern_in = 8'h02; pattern_valid = 1'b1;
        count_window(16);
        chk("fade_p1_ch0", hc[0], 15); chk("fade_p1_ch1", hc[1], 0);
        count_window(16);
        chk("fade_p2_ch0", hc[0], 11); chk("fade_p2_ch1", hc[1], 15);
        count_window(16);
        chk("fade_p3_ch0", hc[0], 3);  chk("fade_p3_ch1", hc[1], 15);
        count_window(16);
        chk("fade_p4_ch0_sat", hc[0], 0); chk("fade_p4_ch1", hc[1], 15);

        // tick, wrap and pattern_valid all on edge 16
        do_reset();
        pattern_in = 8'h01; pattern_valid = 1'b1;
        step();
        pattern_valid = 1'b0;
        repeat (14) step();
        pattern_in = 8'h04; pattern_valid = 1'b1;
        step();
        pattern_valid = 1'b0;
        count_window(16);
        chk("tickv_p1_ch0", hc[0], 15); chk("tickv_p1_ch2", hc[2], 0);
        count_window(16);
        chk("tickv_p2_ch0", hc[0], 7);  chk("tickv_p2_ch2", hc[2], 15);
        count_window(16);
        chk("tickv_p3_ch0", hc[0], 0);  chk("tickv_p3_ch2", hc[2], 15);

        // enable gating for 40 cycles while the fade continues underneath
        do_reset();
        pattern_in = 8'h01; pattern_valid = 1'b1;
        step();
        pattern_valid = 1'b0;
        repeat (8) step();
        enable = 1'b0;
        count_window(7);
        chk("gate_dark_a", hc_sum(), 0);
        pattern_in = 8'h00; pattern_valid = 1'b1;
        count_window(33);
        chk("gate_dark_b", hc_sum(), 0);
        enable = 1'b1;
        count_window(15);
        chk("gate_resume_ch0", hc[0], 2);
        count_window(16);
        chk("gate_after_ch0", hc[0], 0);

        // reset mid-period with a lit channel, then phase restart
        do_reset();
        pattern_in = 8'h01; pattern_valid = 1'b1;
        count_window(16);
        chk("rst_pre_dark", hc[0], 0);
        count_window(4);
        chk("rst_pre_lit", int'(led_out[0]), 1);
        do_reset();
        count_window(16);
        chk("rst_levels_zero", hc_sum(), 0);
        pattern_in = 8'h01; pattern_valid = 1'b1;
        count_window(16);
        chk("rst_duty_zero", hc[0], 0);
        count_window(16);
        chk("rst_restart_count", hc[0], 15);
        chk("rst_restart_phase", int'(led_out[0]), 0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            pattern_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) pattern_in = N'($urandom);
            else pattern_in = N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if (c == 1500) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Downstream stage of the 8-LED chaser: consumes the chaser's 8-bit one-hot pattern and drives the board LEDs through per-channel PWM with a linear fade-out trail ("comet tail"). A channel whose pattern bit is set lights at full brightness. Once its bit clears, the channel dims in fixed steps on a prescaled decay tick until it is off. The block sits between the pattern shift register and the LED0..LED7 pins.

## Interface
- N_LED, 8: number of channels.
- PWM_BITS, 8: brightness/PWM counter width; PWM period = 2^PWM_BITS clocks.
- TICK_DIV, 60000: clocks per decay tick (≥2).
- DECAY_STEP, 16: brightness decrement per tick (1..2^PWM_BITS-1).

Ports:
- iCE_CLK  in  1  system clock; all state is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- pattern_in  in  N_LED  new LED pattern; bit i maps to channel i.
- pattern_valid  in  1  single-cycle strobe; samples pattern_in.
- enable  in  1  0 forces all outputs dark; internal state keeps running.
- led_out  out  N_LED  registered PWM LED drive, active-high.

## Operation
- pwm_cnt: free-running PWM_BITS counter, 0 → 2^PWM_BITS-1 → 0.
- Prescaler: counts 0..TICK_DIV-1. tick is asserted in the cycle the count equals TICK_DIV-1, and the count returns to 0 on the next cycle.
- pat_q[N_LED]: latched pattern. Loaded from pattern_in when pattern_valid=1, otherwise held.
- level[i] (PWM_BITS bits) is updated with this priority:
  - If pattern_valid=1 and pattern_in[i]=1: level ← MAX (all ones).
  - Else, if tick=1 and the effective bit is 0: level ← saturating level − DECAY_STEP, floored at 0. The effective bit is pattern_in[i] when pattern_valid=1 in the same cycle, otherwise pat_q[i].
  - Else, if the effective bit is 1: level holds MAX.
  - Otherwise level holds.
- duty[i]: shadow of level[i], loaded only in the cycle pwm_cnt = 2^PWM_BITS-1. Duty therefore changes only at PWM period boundaries, so no glitched periods occur.
- led_out[i] ← enable & (pwm_cnt < duty[i]).
  - duty = 0 gives a constant 0.
  - duty = MAX gives high for MAX of every 2^PWM_BITS cycles.
- A pattern with several set bits is legal. Channels are fully independent.

## Timing
- Reset (asynchronous assert) clears pwm_cnt, the prescaler, pat_q, every level and every duty, and sets led_out = 0.
- Reset release is synchronous to the next rising edge. On the first active edge the counters start from 0.
- Reset asserted mid-fade or mid-period: everything returns to zero immediately. No partial state survives.
- pattern_valid at edge t: level = MAX after t. duty picks it up at the first edge where pwm_cnt = 2^PWM_BITS-1 at or after t+1. led_out rises one edge later, at the start of the next period.
- Worst-case latency from pattern_valid to a visible LED change is 2^PWM_BITS + 1 clocks.
- A tick coinciding with pattern_valid: set bits go to MAX, and cleared bits decay in that same cycle.
- A tick coinciding with the duty-load cycle: duty loads the pre-tick level; the decayed level appears one period later.
- A full fade from MAX to 0 takes ceil(MAX/DECAY_STEP) ticks.
- enable 1→0: led_out is 0 from the next edge. 0→1: the output resumes mid-period from the current pwm_cnt and duty.

## Structure
- Shared package led_pkg:
  - PWM_BITS default.
  - LEVEL_MAX constant (all ones of PWM_BITS).
  - Saturating-subtract function used for the decay.
- Top-level logic: pwm_cnt, prescaler/tick, pat_q.
- Sub-module led_pwm_channel, instantiated N_LED times through a generate loop.
  - Inputs: pattern bit, valid, tick, pwm_cnt, wrap flag, enable.
  - Holds level, duty and the led_out flop for one channel.

## Test plan
Run with PWM_BITS=4, TICK_DIV=8, DECAY_STEP=4 (period 16, MAX=15).
- Reset check: assert rst mid-run with levels nonzero → led_out=0 at once, all levels/duty 0; after release pwm_cnt restarts at 0.
- Turn-on: pattern_valid with pattern_in=8'h01, enable=1 → from the next period led_out[0] is high 15 of 16 cycles; other channels stay 0.
- Fade: load 8'h01, then load 8'h02 → channel 0 level steps 15→11→7→3→0 on successive ticks; per-period high counts follow with one-period lag. Channel 1 stays at 15.
- Simultaneous tick and pattern_valid (8'h00 loaded on a tick cycle with channel 0 at 15) → channel 0 level is 11 on the next cycle, and channels with new bit 1 are 15.
- Enable gating: enable=0 for 40 cycles during a fade → led_out all 0 throughout; after re-enable, duty equals the value expected from ticks elapsed (decay continued).
- Boundary: DECAY_STEP larger than the current level (level 3, step 4) → level saturates to 0, with no wrap to 15.
